// File: rtl/event_word_packer.sv
// event_word_packer: FIFO-buffered event serializer into WIDTH-bit words; optional EVT_DROP_ON_FULL_EN drops events on full
module event_word_packer #(
  parameter int ROW_ADD = 11,
  parameter int COL_ADD = 11,
  parameter int POLARITY = 2,
  parameter int SIZE = 34,
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int EVT_W = SIZE + POLARITY + ROW_ADD + COL_ADD,
  localparam int NW = (EVT_W + WIDTH - 1) / WIDTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                evt_valid_i,
  output logic                evt_ready_o,
  input  logic [ROW_ADD-1:0]  row_add_i,
  input  logic [COL_ADD-1:0]  col_add_i,
  input  logic [POLARITY-1:0] polarity_i,
  input  logic [SIZE-1:0]     timestamp_i,
  output logic                word_valid_o,
  input  logic                word_ready_i,
  output logic [WIDTH-1:0]    word_data_o,
  output logic                word_first_o,
  output logic                word_last_o,
  output logic [CW-1:0]       fifo_count_o
`ifdef EVT_DROP_ON_FULL_EN
  ,output logic [15:0]        drop_count_o
`endif
);
  localparam int PW = NW * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q, state_d;
  logic [EVT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] shreg_q, shreg_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [EVT_W-1:0] evt;
  logic full, wr, pop, last_w;
  assign evt = {timestamp_i, polarity_i, row_add_i, col_add_i};
  assign full = count_q == CW'(DEPTH);
  assign last_w = idx_q == IW'(NW - 1);
  assign wr = evt_valid_i && !full;
  assign pop = (count_q != '0) && (state_q == IDLE || (word_ready_i && last_w));
`ifdef EVT_DROP_ON_FULL_EN
  assign evt_ready_o = 1'b1;
`else
  assign evt_ready_o = !full;
`endif
  assign word_valid_o = state_q == XFER;
  assign word_data_o = word_valid_o ? shreg_q[WIDTH-1:0] : '0;
  assign word_first_o = word_valid_o && idx_q == '0;
  assign word_last_o = word_valid_o && last_w;
  assign fifo_count_o = count_q;
  // pointer/count bookkeeping and serializer next state; a pop on the last word chains the next event with no bubble
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d = idx_q;
    wptr_d = wptr_q + AW'(wr);
    rptr_d = rptr_q + AW'(pop);
    count_d = count_q + CW'(wr) - CW'(pop);
    if (pop) begin
      state_d = XFER;
      shreg_d = PW'(mem_q[rptr_q]);
      idx_d = '0;
    end else if (state_q == XFER && word_ready_i) begin
      state_d = last_w ? IDLE : XFER;
      shreg_d = shreg_q >> WIDTH;
      idx_d = idx_q + 1'b1;
    end
  end
  // state registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q <= idx_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  // event storage, no reset needed since pointers gate it
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q] <= evt;
  end
`ifdef EVT_DROP_ON_FULL_EN
  logic [15:0] drop_q, drop_d;
  // saturating count of events arriving while full
  always_comb drop_d = (evt_valid_i && full && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  // drop counter register
  always_ff @(posedge clk_i) begin
    if (reset_i) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign drop_count_o = drop_q;
`endif
endmodule

// File: doc/event_word_packer.md
Name: event_word_packer

Overview:
- Sits between the hierarchical event arbiter output and the readout/AXI-stream interface.
- Accepts one granted event per cycle: row address, column address, polarity and timestamp.
- Buffers events in a parametrised FIFO.
- Serialises each event into ceil(EVT_W/WIDTH) words of WIDTH bits over a valid/ready stream, with first/last word markers.

Parameters:
- ROW_ADD, 11, row address width
- COL_ADD, 11, column address width
- POLARITY, 2, polarity width
- SIZE, 34, timestamp width
- WIDTH, 32, output word width (>=8)
- DEPTH, 8, event FIFO entries (power of 2, >=2)
- Derived: EVT_W = SIZE+POLARITY+ROW_ADD+COL_ADD (58 by default); NW = ceil(EVT_W/WIDTH) (2 by default); CW = $clog2(DEPTH+1)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- evt_valid_i  in  1  event present from arbiter
- evt_ready_o  out  1  event accepted this cycle when high with evt_valid_i
- row_add_i  in  ROW_ADD  event row address
- col_add_i  in  COL_ADD  event column address
- polarity_i  in  POLARITY  event polarity
- timestamp_i  in  SIZE  event timestamp
- word_valid_o  out  1  output word valid
- word_ready_i  in  1  downstream accepts word
- word_data_o  out  WIDTH  output word
- word_first_o  out  1  word is first of its event
- word_last_o  out  1  word is last of its event
- fifo_count_o  out  CW  events held in FIFO, excluding the output stage
- drop_count_o  out  16  dropped events; present only with the optional feature

Behaviour:
- Reset: one clock and a synchronous active-high reset (clk_i, reset_i).
  - Clears FIFO pointers and count, serializer state and drop count.
  - All outputs reset to 0, except evt_ready_o = 1.
  - Reset mid-event discards the partial event and all buffered events. word_valid_o is 0 in the cycle after the reset edge.
- Packing: event vector E = {timestamp_i, polarity_i, row_add_i, col_add_i}, col in the LSBs.
  - E is zero-extended to NW*WIDTH bits.
  - Word k = E[k*WIDTH +: WIDTH], sent k = 0 first.
- Input side:
  - evt_ready_o = (fifo_count_o != DEPTH).
  - A write occurs on an edge where evt_valid_i && evt_ready_o.
  - A write and a FIFO pop in the same cycle leave the count unchanged.
  - When full, a pop does not combinationally raise evt_ready_o; ready rises the cycle after the count drops.
- Serializer FSM, states IDLE and XFER:
  - IDLE: word_valid_o = 0 and word_data_o = 0. If the FIFO is non-empty, load the head into the shift register, pop, set idx = 0 and go to XFER.
  - XFER: word_valid_o = 1, word_data_o = shreg[WIDTH-1:0], word_first_o = (idx == 0), word_last_o = (idx == NW-1).
  - On word_ready_i with idx < NW-1: shift right by WIDTH and increment idx.
  - On word_ready_i with idx == NW-1: if the FIFO is non-empty, load the next head, pop, set idx = 0 and stay in XFER (back-to-back, no bubble); otherwise go to IDLE.
  - Without word_ready_i: all outputs hold stable; valid never drops before acceptance.
- Latency:
  - An event accepted on edge E with an empty FIFO and an IDLE serializer is loaded into the output stage on edge E+1.
  - Its first word therefore appears with word_valid_o = 1 in the cycle after edge E+1.
  - A sustained throughput of one word per cycle is required.
- Capacity: DEPTH events in the FIFO plus one in the output stage.
- NW == 1 (WIDTH >= EVT_W): word_first_o and word_last_o are both 1 on every word.
- Event order is preserved strictly.

Optional Feature:
- Macro EVT_DROP_ON_FULL_EN.
- Defined:
  - evt_ready_o is tied to 1.
  - An event arriving while the FIFO is full is discarded and increments drop_count_o.
  - drop_count_o saturates at 16'hFFFF and is cleared only by reset.
- Undefined: drop_count_o and its counter are not present, and backpressure follows the input-side rules above.

Test Plan:
1. Reset: assert reset_i for 2 cycles → word_valid_o = 0, word_data_o = 0, fifo_count_o = 0, evt_ready_o = 1.
2. Single event: row = 0x005, col = 0x3FF, pol = 2'b01, ts = 34'h2_0000_0001, word_ready_i = 1.
   - Required words: 0x01402BFF (first = 1, last = 0), then 0x02000000 (first = 0, last = 1) on the next cycle.
   - First valid appears in the cycle after the second edge following acceptance.
3. Backpressure: as scenario 2 with word_ready_i = 0 for 5 cycles → word 0x01402BFF with first = 1 held stable for all 5 cycles; word_ready_i = 1 then releases both words in order.
4. Fill, DEPTH = 8, word_ready_i = 0: drive 10 events with distinct ts = 1..10.
   - Required: 9 accepted, evt_ready_o = 0 on the 10th, fifo_count_o = 8.
   - With word_ready_i = 1: 18 words on consecutive cycles, ts 1..9 in order, no bubbles.
5. Reset mid-event: assert reset_i after word 0 is accepted with 3 events queued → next cycle word_valid_o = 0 and fifo_count_o = 0; no stale words after reset.
6. EVT_DROP_ON_FULL_EN defined, scenario 4 stimulus → evt_ready_o stays 1, drop_count_o = 1, ts = 10 never emitted; the WIDTH = 64 build emits a single word per event with first = last = 1.
